writeback_unit: RTL and testbench
=================================

# writeback_unit

Writeback stage that feeds the single write port of the integer register file. Merges single-cycle ALU results and variable-latency load responses into one registered write (`rf_wen`/`rf_rd`/`rf_dataD`), buffering loads in a small FIFO when the ALU owns the port. Also keeps a per-register pending-load scoreboard for the issue stage, and forwards the in-flight write to the register-file read ports.

## Interface
- `ADDR_WIDTH`, 5, register index width; register count is 2^ADDR_WIDTH.
- `DATA_WIDTH`, 32, register data width.
- `DEPTH`, 2, load buffer entries; power of two, ≥2.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `alu_valid`  in  1  ALU result commits this cycle; no backpressure.
- `alu_rd`  in  ADDR_WIDTH  ALU destination.
- `alu_data`  in  DATA_WIDTH  ALU result.
- `lsu_valid`  in  1  load response offered.
- `lsu_ready`  out  1  load response accepted when `lsu_valid & lsu_ready`.
- `lsu_rd`  in  ADDR_WIDTH  load destination.
- `lsu_data`  in  DATA_WIDTH  load data.
- `issue_ld_valid`  in  1  a load is issued this cycle.
- `issue_ld_rd`  in  ADDR_WIDTH  destination of the issued load.
- `pending`  out  2^ADDR_WIDTH  bit i set while a load to xi is outstanding.
- `rf_wen`  out  1  register-file write enable.
- `rf_rd`  out  ADDR_WIDTH  register-file write index.
- `rf_dataD`  out  DATA_WIDTH  register-file write data.
- `rs1`, `rs2`  in  ADDR_WIDTH  read indices presented to the register file.
- `fwd1_hit`, `fwd2_hit`  out  1  in-flight write matches rs1/rs2.
- `fwd1_data`, `fwd2_data`  out  DATA_WIDTH  forwarded data (equal to `rf_dataD`).

## Operation
- Output register (`rf_wen`, `rf_rd`, `rf_dataD`) is loaded every cycle from exactly one source, with this priority:
  1. ALU, when `alu_valid`.
  2. FIFO head, when the FIFO is non-empty.
  3. Direct load, when the FIFO is empty and an LSU handshake occurs.
  4. Otherwise idle: `rf_wen`←0, and `rf_rd`/`rf_dataD` hold.
- A load handshake that is not consumed directly is pushed into the FIFO.
- Push and pop may occur in the same cycle; occupancy is then unchanged.
- `lsu_ready = !full`. It is combinational from occupancy only and does not depend on `alu_valid`.
- Destination x0: the source is consumed normally (FIFO pops, handshake completes) but `rf_wen`←0.
- FIFO is in-order, with wrap-around read/write pointers of log2(DEPTH) bits plus a count.
- Scoreboard `pending`:
  - Set bit `issue_ld_rd` on `issue_ld_valid` when rd≠0. Bit 0 is always 0.
  - Clear bit rd on the edge at which a load's entry is loaded into the output register with rd≠0.
  - Set and clear on the same index in the same cycle: set wins.
- Upstream contract (checked by bench assertions, not handled in RTL):
  - No load issued to an rd already pending.
  - No ALU result to a pending rd.
  - No more than DEPTH+1 loads outstanding beyond what `lsu_ready` allows.
- Forwarding: `fwdN_hit = rf_wen & (rf_rd == rsN) & (rsN != 0)`, combinational. `fwdN_data = rf_dataD`. This covers the cycle in which the register file has not yet absorbed the write.

## Timing
- Reset (async assert, sync-safe deassert):
  - `rf_wen`=0, `rf_rd`=0, `rf_dataD`=0, `pending`=0.
  - FIFO empty, so `lsu_ready`=1 and `fwdN_hit`=0.
- Reset mid-operation discards FIFO contents and all pending bits immediately.
- ALU latency: result on `rf_*` one cycle after `alu_valid`. The register file is written at the following edge.
- Load latency:
  - 1 cycle when the FIFO is empty and `alu_valid`=0.
  - Otherwise 1 + (cycles spent waiting behind ALU results and older FIFO entries).
- Pending bit deasserts in the same cycle `rf_wen` shows the load, and `fwd*_hit` covers that cycle.
- Full FIFO: `lsu_ready`=0. A pop in that cycle does not raise `lsu_ready` until the next cycle.
- Continuous `alu_valid` starves the FIFO; no fairness is required. The issue stage bounds this through the scoreboard.

## Test plan
- Reset, then `alu_valid`=1, `alu_rd`=5, `alu_data`=0x1234 for one cycle -> next cycle `rf_wen`=1, `rf_rd`=5, `rf_dataD`=0x1234; with rs1=5, `fwd1_hit`=1 and `fwd1_data`=0x1234.
- Issue a load to x7, then a 1-cycle LSU response 0xDEAD with the ALU idle -> `pending[7]`=1 from the cycle after issue; next cycle `rf_wen`=1, `rf_rd`=7, `rf_dataD`=0xDEAD and `pending[7]`=0.
- ALU busy 4 cycles (x1..x4) while LSU offers x8, x9, x10 back-to-back -> x8 and x9 buffered; `lsu_ready`=0 while x10 waits; writes appear in order x1,x2,x3,x4,x8,x9,x10 with no loss.
- Writes to x0 from both ALU and LSU -> `rf_wen` stays 0, FIFO drains, `pending[0]` never sets, `fwd*_hit`=0 with rs1=rs2=0.
- Same-cycle set/clear: load to x3 retires as a new load to x3 issues -> `pending[3]` remains 1.
- Assert `rst_n`=0 with 2 FIFO entries and `pending`=0x0180 -> all outputs at reset values immediately; after release, `lsu_ready`=1 and no stale writes appear.

Source files
------------

// File: rtl/writeback_unit_if.sv
// Writeback port bundle: ALU commit, LSU load response, load issue, RF write and forwarding.
// Pure wiring, no latency of its own.
// lsu_valid/lsu_ready carry the only backpressure; the ALU and issue inputs cannot be stalled.
interface writeback_unit_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  localparam int NREGS = 1 << ADDR_WIDTH;

  // ALU commit (no backpressure)
  logic                  alu_valid;
  logic [ADDR_WIDTH-1:0] alu_rd;
  logic [DATA_WIDTH-1:0] alu_data;

  // LSU load response (valid/ready)
  logic                  lsu_valid;
  logic                  lsu_ready;
  logic [ADDR_WIDTH-1:0] lsu_rd;
  logic [DATA_WIDTH-1:0] lsu_data;

  // Load issue notification and per-register pending scoreboard
  logic                  issue_ld_valid;
  logic [ADDR_WIDTH-1:0] issue_ld_rd;
  logic [NREGS-1:0]      pending;

  // Register-file write port
  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_rd;
  logic [DATA_WIDTH-1:0] rf_dataD;

  // Register-file read indices and forwarding of the in-flight write
  logic [ADDR_WIDTH-1:0] rs1;
  logic [ADDR_WIDTH-1:0] rs2;
  logic                  fwd1_hit;
  logic                  fwd2_hit;
  logic [DATA_WIDTH-1:0] fwd1_data;
  logic [DATA_WIDTH-1:0] fwd2_data;

  // Writeback unit side
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output lsu_ready,
    input  issue_ld_valid, issue_ld_rd,
    output pending,
    output rf_wen, rf_rd, rf_dataD,
    input  rs1, rs2,
    output fwd1_hit, fwd2_hit, fwd1_data, fwd2_data
  );

  // Pipeline / environment side
  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  lsu_ready,
    output issue_ld_valid, issue_ld_rd,
    input  pending,
    input  rf_wen, rf_rd, rf_dataD,
    output rs1, rs2,
    input  fwd1_hit, fwd2_hit, fwd1_data, fwd2_data
  );
endinterface

// File: rtl/writeback_unit.sv
// Writeback stage: merges ALU results and load responses into one registered RF write, tracks pending loads, forwards the in-flight write.
// Latency: 1 cycle from ALU valid or an unblocked load handshake to rf_wen; buffered loads wait behind ALU results and older entries.
// Backpressure: lsu_ready = !full of the load buffer; ALU always wins the write port and is never stalled.
module writeback_unit #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  writeback_unit_if.slave  wb
);

  localparam int NREGS = 1 << ADDR_WIDTH;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  // Load buffer state
  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Output register and scoreboard
  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_rd_q, rf_rd_d;
  logic [DATA_WIDTH-1:0] rf_data_q, rf_data_d;
  logic [NREGS-1:0]      pending_q, pending_d;

  logic   fifo_empty;
  logic   fifo_full;
  logic   lsu_hs;
  logic   push;
  logic   pop;
  logic   src_vld;
  logic   src_is_ld;
  entry_t src;
  entry_t lsu_entry;
  entry_t head;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(DEPTH));
  assign lsu_hs     = wb.lsu_valid & ~fifo_full;
  assign lsu_entry  = '{rd: wb.lsu_rd, data: wb.lsu_data};
  assign head       = mem_q[rd_ptr_q];

  // Pick the single source for the write port and decide buffer push/pop
  always_comb begin
    src_vld   = 1'b0;
    src_is_ld = 1'b0;
    src       = '{rd: rf_rd_q, data: rf_data_q};
    pop       = 1'b0;
    push      = 1'b0;
    if (wb.alu_valid) begin
      src_vld = 1'b1;
      src     = '{rd: wb.alu_rd, data: wb.alu_data};
      push    = lsu_hs;
    end else if (!fifo_empty) begin
      src_vld   = 1'b1;
      src_is_ld = 1'b1;
      src       = head;
      pop       = 1'b1;
      push      = lsu_hs;
    end else if (lsu_hs) begin
      // Buffer is empty and the port is free: load bypasses the buffer
      src_vld   = 1'b1;
      src_is_ld = 1'b1;
      src       = lsu_entry;
    end
  end

  // Next state of the output register: writes to x0 consume the source but never write
  always_comb begin
    rf_wen_d  = src_vld & (src.rd != '0);
    rf_rd_d   = rf_rd_q;
    rf_data_d = rf_data_q;
    if (src_vld) begin
      rf_rd_d   = src.rd;
      rf_data_d = src.data;
    end
  end

  // Buffer pointers and occupancy; simultaneous push and pop leaves count unchanged
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Scoreboard: clear on load retirement first so a same-index issue wins
  always_comb begin
    pending_d = pending_q;
    if (src_is_ld && (src.rd != '0)) pending_d[src.rd] = 1'b0;
    if (wb.issue_ld_valid && (wb.issue_ld_rd != '0)) pending_d[wb.issue_ld_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // Buffer storage: data only, validity is tracked by pointers and count
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= lsu_entry;
  end

  // Control state with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rf_wen_q  <= 1'b0;
      rf_rd_q   <= '0;
      rf_data_q <= '0;
      pending_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rf_wen_q  <= rf_wen_d;
      rf_rd_q   <= rf_rd_d;
      rf_data_q <= rf_data_d;
      pending_q <= pending_d;
    end
  end

  // Outputs: registered write port, occupancy-only ready, combinational forwarding
  assign wb.lsu_ready = ~fifo_full;
  assign wb.pending   = pending_q;
  assign wb.rf_wen    = rf_wen_q;
  assign wb.rf_rd     = rf_rd_q;
  assign wb.rf_dataD  = rf_data_q;
  assign wb.fwd1_hit  = rf_wen_q & (rf_rd_q == wb.rs1) & (wb.rs1 != '0);
  assign wb.fwd2_hit  = rf_wen_q & (rf_rd_q == wb.rs2) & (wb.rs2 != '0);
  assign wb.fwd1_data = rf_data_q;
  assign wb.fwd2_data = rf_data_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: reset, ALU path, direct load, buffering, x0, scoreboard races, mid-run reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled in the same window.
// Each scenario task compares inline and bumps the shared counters.
module tb_writeback_unit;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  writeback_unit_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) wb ();

  writeback_unit #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream contract: no ALU result to a register with a load outstanding
  always @(posedge clk) begin
    if (rst_n && wb.alu_valid && wb.alu_rd != 5'd0)
      assert (wb.pending[wb.alu_rd] == 1'b0) else $error("ALU write to pending register x%0d", wb.alu_rd);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb.alu_valid      = 1'b0;
    wb.alu_rd         = '0;
    wb.alu_data       = '0;
    wb.lsu_valid      = 1'b0;
    wb.lsu_rd         = '0;
    wb.lsu_data       = '0;
    wb.issue_ld_valid = 1'b0;
    wb.issue_ld_rd    = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    wb.rs1 = 5'd0;
    wb.rs2 = 5'd0;
    rst_n  = 1'b0;
    #12;
    tests++; if (wb.rf_wen !== 1'b0) begin fails++; $display("FAIL reset_wen got=%b exp=0", wb.rf_wen); end
    tests++; if (wb.rf_rd !== 5'd0) begin fails++; $display("FAIL reset_rd got=%0d exp=0", wb.rf_rd); end
    tests++; if (wb.rf_dataD !== 32'd0) begin fails++; $display("FAIL reset_data got=%h exp=0", wb.rf_dataD); end
    tests++; if (wb.pending !== 32'd0) begin fails++; $display("FAIL reset_pending got=%h exp=0", wb.pending); end
    tests++; if (wb.lsu_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", wb.lsu_ready); end
    tests++; if (wb.fwd1_hit !== 1'b0 || wb.fwd2_hit !== 1'b0) begin fails++; $display("FAIL reset_fwd got=%b%b exp=00", wb.fwd1_hit, wb.fwd2_hit); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_alu();
    wb.alu_valid = 1'b1;
    wb.alu_rd    = 5'd5;
    wb.alu_data  = 32'h1234;
    wb.rs1       = 5'd5;
    step();
    idle_inputs();
    tests++; if (wb.rf_wen !== 1'b1) begin fails++; $display("FAIL alu_wen got=%b exp=1", wb.rf_wen); end
    tests++; if (wb.rf_rd !== 5'd5) begin fails++; $display("FAIL alu_rd got=%0d exp=5", wb.rf_rd); end
    tests++; if (wb.rf_dataD !== 32'h1234) begin fails++; $display("FAIL alu_data got=%h exp=1234", wb.rf_dataD); end
    tests++; if (wb.fwd1_hit !== 1'b1) begin fails++; $display("FAIL alu_fwd1_hit got=%b exp=1", wb.fwd1_hit); end
    tests++; if (wb.fwd1_data !== 32'h1234) begin fails++; $display("FAIL alu_fwd1_data got=%h exp=1234", wb.fwd1_data); end
    step();
    tests++; if (wb.rf_wen !== 1'b0) begin fails++; $display("FAIL alu_idle_wen got=%b exp=0", wb.rf_wen); end
    tests++; if (wb.rf_rd !== 5'd5) begin fails++; $display("FAIL alu_idle_rd_hold got=%0d exp=5", wb.rf_rd); end
    tests++; if (wb.fwd1_hit !== 1'b0) begin fails++; $display("FAIL alu_idle_fwd got=%b exp=0", wb.fwd1_hit); end
    wb.rs1 = 5'd0;
  endtask

  task automatic test_load();
    wb.issue_ld_valid = 1'b1;
    wb.issue_ld_rd    = 5'd7;
    step();
    idle_inputs();
    tests++; if (wb.pending[7] !== 1'b1) begin fails++; $display("FAIL load_pending_set got=%b exp=1", wb.pending[7]); end
    wb.lsu_valid = 1'b1;
    wb.lsu_rd    = 5'd7;
    wb.lsu_data  = 32'hDEAD;
    wb.rs2       = 5'd7;
    #1;
    tests++; if (wb.lsu_ready !== 1'b1) begin fails++; $display("FAIL load_ready got=%b exp=1", wb.lsu_ready); end
    step();
    idle_inputs();
    tests++; if (wb.rf_wen !== 1'b1 || wb.rf_rd !== 5'd7) begin fails++; $display("FAIL load_write got wen=%b rd=%0d exp wen=1 rd=7", wb.rf_wen, wb.rf_rd); end
    tests++; if (wb.rf_dataD !== 32'hDEAD) begin fails++; $display("FAIL load_data got=%h exp=dead", wb.rf_dataD); end
    tests++; if (wb.pending[7] !== 1'b0) begin fails++; $display("FAIL load_pending_clr got=%b exp=0", wb.pending[7]); end
    tests++; if (wb.fwd2_hit !== 1'b1 || wb.fwd2_data !== 32'hDEAD) begin fails++; $display("FAIL load_fwd2 got hit=%b data=%h exp hit=1 data=dead", wb.fwd2_hit, wb.fwd2_data); end
    wb.rs2 = 5'd0;
    step();
  endtask

  task automatic test_back_to_back();
    // Per cycle: ALU rd (0 = idle), LSU rd offered (0 = none), expected lsu_ready, expected write rd after the edge
    logic [4:0] alu_tab [8];
    logic [4:0] lsu_tab [8];
    logic       rdy_tab [8];
    logic [4:0] exp_tab [8];
    alu_tab = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0};
    lsu_tab = '{5'd8, 5'd9, 5'd10, 5'd10, 5'd10, 5'd10, 5'd0, 5'd0};
    rdy_tab = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_tab = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd8, 5'd9, 5'd10, 5'd0};
    for (int i = 0; i < 8; i++) begin
      wb.alu_valid = (alu_tab[i] != 5'd0);
      wb.alu_rd    = alu_tab[i];
      wb.alu_data  = 32'h100 + 32'(alu_tab[i]);
      wb.lsu_valid = (lsu_tab[i] != 5'd0);
      wb.lsu_rd    = lsu_tab[i];
      wb.lsu_data  = 32'h800 + 32'(lsu_tab[i]);
      #1;
      tests++; if (wb.lsu_ready !== rdy_tab[i]) begin fails++; $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", i, wb.lsu_ready, rdy_tab[i]); end
      step();
      if (exp_tab[i] == 5'd0) begin
        tests++; if (wb.rf_wen !== 1'b0) begin fails++; $display("FAIL b2b_idle cyc=%0d got wen=%b exp=0", i, wb.rf_wen); end
      end else begin
        tests++;
        if (wb.rf_wen !== 1'b1 || wb.rf_rd !== exp_tab[i] ||
            wb.rf_dataD !== ((exp_tab[i] >= 5'd8 ? 32'h800 : 32'h100) + 32'(exp_tab[i]))) begin
          fails++;
          $display("FAIL b2b_write cyc=%0d got wen=%b rd=%0d data=%h exp rd=%0d", i, wb.rf_wen, wb.rf_rd, wb.rf_dataD, exp_tab[i]);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_x0();
    wb.rs1            = 5'd0;
    wb.rs2            = 5'd0;
    wb.alu_valid      = 1'b1;
    wb.alu_rd         = 5'd0;
    wb.alu_data       = 32'hAA;
    wb.lsu_valid      = 1'b1;
    wb.lsu_rd         = 5'd0;
    wb.lsu_data       = 32'hBB;
    wb.issue_ld_valid = 1'b1;
    wb.issue_ld_rd    = 5'd0;
    step();
    idle_inputs();
    tests++; if (wb.rf_wen !== 1'b0) begin fails++; $display("FAIL x0_alu_wen got=%b exp=0", wb.rf_wen); end
    tests++; if (wb.pending[0] !== 1'b0) begin fails++; $display("FAIL x0_pending got=%b exp=0", wb.pending[0]); end
    tests++; if (wb.fwd1_hit !== 1'b0 || wb.fwd2_hit !== 1'b0) begin fails++; $display("FAIL x0_fwd got=%b%b exp=00", wb.fwd1_hit, wb.fwd2_hit); end
    step();
    tests++; if (wb.rf_wen !== 1'b0) begin fails++; $display("FAIL x0_lsu_wen got=%b exp=0", wb.rf_wen); end
    // Buffer must be empty now: a fresh load goes straight through
    wb.lsu_valid = 1'b1;
    wb.lsu_rd    = 5'd6;
    wb.lsu_data  = 32'h66;
    step();
    idle_inputs();
    tests++; if (wb.rf_wen !== 1'b1 || wb.rf_rd !== 5'd6 || wb.rf_dataD !== 32'h66) begin fails++; $display("FAIL x0_drained got wen=%b rd=%0d data=%h exp wen=1 rd=6 data=66", wb.rf_wen, wb.rf_rd, wb.rf_dataD); end
    step();
  endtask

  task automatic test_same_cycle();
    wb.issue_ld_valid = 1'b1;
    wb.issue_ld_rd    = 5'd3;
    step();
    tests++; if (wb.pending[3] !== 1'b1) begin fails++; $display("FAIL race_pending_set got=%b exp=1", wb.pending[3]); end
    // Retire the load to x3 while a new load to x3 issues
    wb.lsu_valid = 1'b1;
    wb.lsu_rd    = 5'd3;
    wb.lsu_data  = 32'h33;
    step();
    idle_inputs();
    tests++; if (wb.rf_wen !== 1'b1 || wb.rf_rd !== 5'd3) begin fails++; $display("FAIL race_write got wen=%b rd=%0d exp wen=1 rd=3", wb.rf_wen, wb.rf_rd); end
    tests++; if (wb.pending[3] !== 1'b1) begin fails++; $display("FAIL race_set_wins got=%b exp=1", wb.pending[3]); end
    wb.lsu_valid = 1'b1;
    wb.lsu_rd    = 5'd3;
    wb.lsu_data  = 32'h34;
    step();
    idle_inputs();
    tests++; if (wb.pending[3] !== 1'b0) begin fails++; $display("FAIL race_final_clr got=%b exp=0", wb.pending[3]); end
    step();
  endtask

  task automatic test_reset_mid();
    wb.issue_ld_valid = 1'b1;
    wb.issue_ld_rd    = 5'd7;
    wb.alu_valid      = 1'b1;
    wb.alu_rd         = 5'd1;
    wb.alu_data       = 32'h1;
    step();
    wb.issue_ld_rd = 5'd8;
    wb.alu_rd      = 5'd2;
    wb.lsu_valid   = 1'b1;
    wb.lsu_rd      = 5'd7;
    wb.lsu_data    = 32'h77;
    step();
    wb.issue_ld_valid = 1'b0;
    wb.alu_rd         = 5'd3;
    wb.lsu_rd         = 5'd8;
    wb.lsu_data       = 32'h88;
    step();
    wb.alu_rd    = 5'd4;
    wb.lsu_valid = 1'b0;
    #1;
    tests++; if (wb.pending !== 32'h0000_0180) begin fails++; $display("FAIL rstmid_pre_pending got=%h exp=00000180", wb.pending); end
    tests++; if (wb.lsu_ready !== 1'b0) begin fails++; $display("FAIL rstmid_pre_full got=%b exp=0", wb.lsu_ready); end
    rst_n = 1'b0;
    idle_inputs();
    #1;
    tests++; if (wb.rf_wen !== 1'b0 || wb.rf_rd !== 5'd0 || wb.rf_dataD !== 32'd0) begin fails++; $display("FAIL rstmid_out got wen=%b rd=%0d data=%h exp 0/0/0", wb.rf_wen, wb.rf_rd, wb.rf_dataD); end
    tests++; if (wb.pending !== 32'd0) begin fails++; $display("FAIL rstmid_pending got=%h exp=0", wb.pending); end
    tests++; if (wb.lsu_ready !== 1'b1) begin fails++; $display("FAIL rstmid_ready got=%b exp=1", wb.lsu_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if (wb.rf_wen !== 1'b0) begin fails++; $display("FAIL rstmid_stale cyc=%0d got wen=%b exp=0", i, wb.rf_wen); end
    end
    tests++; if (wb.lsu_ready !== 1'b1) begin fails++; $display("FAIL rstmid_ready_after got=%b exp=1", wb.lsu_ready); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b1;
    idle_inputs();
    wb.rs1 = 5'd0;
    wb.rs2 = 5'd0;
    test_reset();
    test_alu();
    test_load();
    test_back_to_back();
    test_x0();
    test_same_cycle();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
